alu_control_seq: RTL and testbench
==================================

# alu_control_seq

Parametrised ALU control-and-execute unit for the MIPS datapath. It decodes `alu_op`/`funct` into the 4-bit ALU control code, executes the operation on WIDTH-bit operands, and adds iterative multi-cycle multiply and unsigned divide behind a valid/ready handshake. It sits in the EX stage and replaces the combinational decoder. Single-cycle ops complete in one cycle; MUL/DIV ops stall the issuing stage through `in_ready`.

## Interface
- `WIDTH`, 32, operand/result width; legal range 8..64.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operation request.
- `in_ready`  output  1  block can accept; high only in IDLE.
- `alu_op`  input  3  main-control ALU class.
- `funct`  input  6  R-type function field; used only when `alu_op`=000.
- `op_a`, `op_b`  input  WIDTH  operands.
- `out_valid`  output  1  result valid; held until accepted.
- `out_ready`  input  1  consumer accepts result.
- `result`  output  WIDTH  registered result.
- `alu_cnt`  output  4  registered decoded control code of the captured op.
- `zero`  output  1  `result`==0.
- `illegal`  output  1  captured op decoded as undefined.

## Operation
- Decode: `alu_op` 001→0001 SUB; 010→0111 SLT; 011→0000 ADD; 000→by `funct`; 1xx→illegal.
- `funct` map: 000000→0000 ADD, 000001→0001 SUB, 000010→0101 NOR, 000011→0110 SLTU, 000100→0111 SLT, 000101→0011 OR, 000110→0100 XOR, 000111→0010 AND, 001000→1000 MUL (low WIDTH bits), 001001→1001 MULHU (high WIDTH bits, unsigned), 001010→1010 DIVU, 001011→1011 REMU; any other→illegal.
- Arithmetic modulo 2^WIDTH; overflow ignored. SLT signed, SLTU unsigned; result is 1 or 0, zero-extended.
- Illegal op: `illegal`=1, `result`=0, `alu_cnt`=1111, single-cycle path.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on `in_valid`&&`in_ready`, capture operands and decode. Single-cycle/illegal: compute, register `result`/`alu_cnt`/`illegal`, go to DONE. MUL/MULHU: go to MUL. DIVU/REMU: go to DIV.
  - MUL: unsigned shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator; after WIDTH iterations register the selected half, go to DONE.
  - DIV: restoring division, one quotient bit per cycle; after WIDTH iterations register quotient or remainder, go to DONE.
  - DONE: `out_valid`=1. On `out_ready` go to IDLE.
- Iteration counter width is $clog2(WIDTH)+1; it is cleared on entry to MUL/DIV.
- Divide by zero has no special case; the restoring algorithm yields quotient = all ones and remainder = `op_a`.
- Inputs are sampled only at acceptance; changes while busy are ignored.

## Timing
- Reset: state IDLE; `in_ready`=1; `out_valid`, `result`, `alu_cnt`, `zero`, `illegal` all 0; counter 0.
- `in_ready` is decoded combinationally from state (IDLE); it never depends on `in_valid`.
- Single-cycle op: accepted at edge N, `out_valid` high after edge N.
- MUL/DIV op: accepted at edge N, `out_valid` high after edge N+WIDTH+1.
- Output handshake completes at the edge where `out_valid`&&`out_ready`. `in_ready` rises after that edge. Maximum throughput is one single-cycle op per 2 cycles.
- `result`, `alu_cnt`, `illegal` are stable while `out_valid`=1; `zero` is derived from registered `result`.
- `out_ready` held high before DONE has no effect. `in_valid` outside IDLE is ignored.
- Reset asserted mid-MUL/DIV/DONE: asynchronous return to IDLE with reset values; the in-flight op is lost and no `out_valid` is produced.

## Test plan
- ADD, `alu_op`=011, a=0xFFFFFFFF, b=1 → after 1 cycle result=0, zero=1, alu_cnt=0000.
- SLT vs SLTU, a=0xFFFFFFFF, b=1: funct 000100 → result=1; funct 000011 → result=0.
- MULHU, a=b=0xFFFFFFFF → out_valid exactly 33 cycles after accept, result=0xFFFFFFFE. MUL with the same operands → result=0x00000001.
- DIVU a=100, b=7 → result=14; REMU → result=2. DIVU a=0x1234, b=0 → 0xFFFFFFFF; REMU → 0x1234.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, a new in_valid is ignored. funct 111111 → illegal=1, result=0, alu_cnt=1111.
- Assert rst_n=0 at iteration 10 of DIV → in_ready=1 and out_valid=0 immediately. The next ADD 2+3 completes with result=5.

Source files
------------

// File: rtl/alu_control_seq.sv
// alu_control_seq
//   EX-stage ALU control and execute unit. Decodes alu_op/funct into a 4-bit
//   control code, runs single-cycle ops directly, and runs multiply
//   (MUL/MULHU) and unsigned divide (DIVU/REMU) iteratively, one bit per cycle.
//   WIDTH is meant to stay within 8..64.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request, sampled only while in_ready
//   in_ready   high only in IDLE
//   alu_op     main-control ALU class
//   funct      R-type function field (used when alu_op = 000)
//   op_a/op_b  operands
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     registered result
//   alu_cnt    registered control code of the captured op (1111 = illegal)
//   zero       result == 0, qualified by out_valid
//   illegal    captured op decoded as undefined
//
// state | meaning
// IDLE  | waiting for a request; in_ready = 1
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result held; out_valid = 1 until out_ready

module alu_control_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       alu_cnt,
   output logic             zero,
   output logic             illegal
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0]   opb_q, opb_nxt;
   logic [WIDTH-1:0]   result_nxt;
   logic [3:0]         code_nxt;
   logic               illegal_nxt;

   logic [3:0]         dec_code;
   logic               dec_illegal;
   logic [WIDTH-1:0]   alu_y;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_acc;
   logic [WIDTH:0]     div_rem_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_acc;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   // Qualified by out_valid so that zero reads 0 out of reset and while busy.
   assign zero      = out_valid && (result == '0);

   always_comb begin
      dec_illegal = 1'b0;
      dec_code    = 4'b0000;
      case (alu_op)
         3'b000: begin
            case (funct)
               6'b000000: dec_code = 4'b0000;
               6'b000001: dec_code = 4'b0001;
               6'b000010: dec_code = 4'b0101;
               6'b000011: dec_code = 4'b0110;
               6'b000100: dec_code = 4'b0111;
               6'b000101: dec_code = 4'b0011;
               6'b000110: dec_code = 4'b0100;
               6'b000111: dec_code = 4'b0010;
               6'b001000: dec_code = 4'b1000;
               6'b001001: dec_code = 4'b1001;
               6'b001010: dec_code = 4'b1010;
               6'b001011: dec_code = 4'b1011;
               default:   dec_illegal = 1'b1;
            endcase
         end
         3'b001:  dec_code = 4'b0001;
         3'b010:  dec_code = 4'b0111;
         3'b011:  dec_code = 4'b0000;
         default: dec_illegal = 1'b1;
      endcase
      if (dec_illegal) begin
         dec_code = 4'b1111;
      end
   end

   always_comb begin
      alu_y = '0;
      case (dec_code)
         4'b0000: alu_y = op_a + op_b;
         4'b0001: alu_y = op_a - op_b;
         4'b0010: alu_y = op_a & op_b;
         4'b0011: alu_y = op_a | op_b;
         4'b0100: alu_y = op_a ^ op_b;
         4'b0101: alu_y = ~(op_a | op_b);
         4'b0110: alu_y = WIDTH'(op_a < op_b);
         4'b0111: alu_y = WIDTH'($signed(op_a) < $signed(op_b));
         default: alu_y = '0;
      endcase
   end

   // Multiply: acc = {partial product high half, remaining multiplier bits}.
   // Add the multiplicand into the high half when the current multiplier bit
   // is set, then shift the whole thing (carry included) right by one.
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_q} : '0);
   assign mul_acc = {mul_sum, acc[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend bits / quotient bits}.
   // A zero divisor always "fits", giving quotient all ones, remainder op_a.
   assign div_rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_ge     = (div_rem_sh >= {1'b0, opb_q});
   assign div_diff   = div_rem_sh - {1'b0, opb_q};
   assign div_acc    = {(div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      acc_nxt     = acc;
      opb_nxt     = opb_q;
      result_nxt  = result;
      code_nxt    = alu_cnt;
      illegal_nxt = illegal;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               code_nxt    = dec_code;
               illegal_nxt = dec_illegal;
               opb_nxt     = op_b;
               cnt_nxt     = '0;
               acc_nxt     = {{WIDTH{1'b0}}, op_a};
               if (dec_illegal) begin
                  result_nxt = '0;
                  state_nxt  = S_DONE;
               end else if (dec_code[3:1] == 3'b100) begin
                  state_nxt = S_MUL;
               end else if (dec_code[3:1] == 3'b101) begin
                  state_nxt = S_DIV;
               end else begin
                  result_nxt = alu_y;
                  state_nxt  = S_DONE;
               end
            end
         end
         S_MUL: begin
            if (cnt == CNT_LAST) begin
               // code bit 0 selects MULHU (high half) over MUL (low half)
               result_nxt = alu_cnt[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
               state_nxt  = S_DONE;
            end else begin
               acc_nxt = mul_acc;
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_DIV: begin
            if (cnt == CNT_LAST) begin
               // code bit 0 selects REMU (remainder) over DIVU (quotient)
               result_nxt = alu_cnt[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
               state_nxt  = S_DONE;
            end else begin
               acc_nxt = div_acc;
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         acc     <= '0;
         opb_q   <= '0;
         result  <= '0;
         alu_cnt <= 4'b0000;
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         acc     <= acc_nxt;
         opb_q   <= opb_nxt;
         result  <= result_nxt;
         alu_cnt <= code_nxt;
         illegal <= illegal_nxt;
      end
   end

endmodule

// File: tb/tb_alu_control_seq.sv
module tb_alu_control_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    alu_op = '0;
   logic [5:0]    funct = '0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic [3:0]    alu_cnt;
   logic          zero;
   logic          illegal;

   int checks = 0;
   int errors = 0;

   alu_control_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .alu_cnt(alu_cnt), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: what the spec says the op produces, plain arithmetic.
   typedef struct packed {
      logic          ill;
      logic [3:0]    code;
      logic [W-1:0]  res;
      logic          multi;
   } exp_t;

   function automatic exp_t model_op(input logic [2:0] aop, input logic [5:0] fn,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [2*W-1:0] prod;
      e = '0;
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      if (aop == 3'b001)      begin e.code = 4'd1; e.res = a - b; end
      else if (aop == 3'b010) begin e.code = 4'd7; e.res = ($signed(a) < $signed(b)) ? 1 : 0; end
      else if (aop == 3'b011) begin e.code = 4'd0; e.res = a + b; end
      else if (aop == 3'b000) begin
         case (fn)
            6'd0:  begin e.code = 4'd0;  e.res = a + b; end
            6'd1:  begin e.code = 4'd1;  e.res = a - b; end
            6'd2:  begin e.code = 4'd5;  e.res = ~(a | b); end
            6'd3:  begin e.code = 4'd6;  e.res = (a < b) ? 1 : 0; end
            6'd4:  begin e.code = 4'd7;  e.res = ($signed(a) < $signed(b)) ? 1 : 0; end
            6'd5:  begin e.code = 4'd3;  e.res = a | b; end
            6'd6:  begin e.code = 4'd4;  e.res = a ^ b; end
            6'd7:  begin e.code = 4'd2;  e.res = a & b; end
            6'd8:  begin e.code = 4'd8;  e.res = prod[W-1:0];   e.multi = 1; end
            6'd9:  begin e.code = 4'd9;  e.res = prod[2*W-1:W]; e.multi = 1; end
            6'd10: begin e.code = 4'd10; e.res = (b == 0) ? '1 : a / b; e.multi = 1; end
            6'd11: begin e.code = 4'd11; e.res = (b == 0) ? a : a % b;  e.multi = 1; end
            default: begin e.ill = 1; e.code = 4'hF; e.res = '0; end
         endcase
      end else begin
         e.ill = 1; e.code = 4'hF; e.res = '0;
      end
      return e;
   endfunction

   // 0 = idle, 1 = busy (counting down latency), 2 = result presented
   int   m_state = 0;
   int   m_left  = 0;
   exp_t m_exp   = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 0;
         m_left  <= 0;
      end else begin
         case (m_state)
            0: if (in_valid) begin
                  m_exp <= model_op(alu_op, funct, op_a, op_b);
                  if (model_op(alu_op, funct, op_a, op_b).multi) begin
                     m_left  <= W + 1;
                     m_state <= 1;
                  end else begin
                     m_state <= 2;
                  end
               end
            1: begin
                  if (m_left == 1) m_state <= 2;
                  m_left <= m_left - 1;
               end
            default: if (out_ready) m_state <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, m_state == 0);
      chk("out_valid", out_valid, m_state == 2);
      if (m_state == 2) begin
         chk("result", result, m_exp.res);
         chk("alu_cnt", alu_cnt, m_exp.code);
         chk("illegal", illegal, m_exp.ill);
         chk("zero", zero, m_exp.res == 0);
      end
   end

   task automatic do_op(input string nm, input logic [2:0] aop, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic [3:0] exp_code,
                        input int exp_lat, input bit hold);
      int n;
      bit seen;
      logic [W-1:0] held;
      @(negedge clk);
      alu_op = aop; funct = fn; op_a = a; op_b = b;
      in_valid = 1'b1;
      out_ready = !hold;
      @(negedge clk);
      in_valid = 1'b0;
      op_a = $urandom;
      op_b = $urandom;
      n = 0;
      seen = out_valid;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         seen = out_valid;
      end
      chk({nm, "_done"}, seen, 1'b1);
      chk({nm, "_latency"}, n, exp_lat);
      chk({nm, "_res"}, result, exp_res);
      chk({nm, "_code"}, alu_cnt, exp_code);
      chk({nm, "_model"}, m_exp.res, exp_res);
      if (hold) begin
         held = result;
         for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            alu_op = 3'b011; op_a = 32'd1; op_b = 32'd1;
            @(negedge clk);
            chk({nm, "_hold_res"}, result, held);
            chk({nm, "_hold_inrdy"}, in_ready, 1'b0);
            chk({nm, "_hold_oval"}, out_valid, 1'b1);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         chk({nm, "_release"}, in_ready, 1'b1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, 0);
      chk("rst_alu_cnt", alu_cnt, 0);
      chk("rst_zero", zero, 1'b0);
      chk("rst_illegal", illegal, 1'b0);
      rst_n = 1'b1;

      do_op("add_wrap", 3'b011, 6'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0000, 0, 0);
      do_op("slt",  3'b000, 6'd4, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0111, 0, 0);
      do_op("sltu", 3'b000, 6'd3, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0110, 0, 0);
      do_op("mulhu", 3'b000, 6'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1001, 33, 0);
      do_op("mul",   3'b000, 6'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b1000, 33, 0);
      do_op("mul2",  3'b000, 6'd8, 32'h00012345, 32'h00000100, 32'h01234500, 4'b1000, 33, 0);
      do_op("divu",  3'b000, 6'd10, 32'd100, 32'd7, 32'd14, 4'b1010, 33, 0);
      do_op("remu",  3'b000, 6'd11, 32'd100, 32'd7, 32'd2, 4'b1011, 33, 0);
      do_op("divu0", 3'b000, 6'd10, 32'h1234, 32'd0, 32'hFFFFFFFF, 4'b1010, 33, 0);
      do_op("remu0", 3'b000, 6'd11, 32'h1234, 32'd0, 32'h00001234, 4'b1011, 33, 0);
      do_op("sub_bp", 3'b001, 6'd0, 32'd10, 32'd3, 32'd7, 4'b0001, 0, 1);
      do_op("ill_funct", 3'b000, 6'h3F, 32'd5, 32'd6, 32'd0, 4'b1111, 0, 0);
      do_op("ill_aop", 3'b100, 6'd0, 32'd5, 32'd6, 32'd0, 4'b1111, 0, 0);
      do_op("slt_aop", 3'b010, 6'd0, 32'hFFFFFFFB, 32'd3, 32'd1, 4'b0111, 0, 0);
      do_op("nor", 3'b000, 6'd2, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 4'b0101, 0, 0);
      do_op("xor", 3'b000, 6'd6, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 4'b0100, 0, 0);
      do_op("and", 3'b000, 6'd7, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 4'b0010, 0, 0);
      do_op("or",  3'b000, 6'd5, 32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 4'b0011, 0, 0);
      do_op("sub_neg", 3'b000, 6'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b0001, 0, 0);

      // reset in the middle of a divide
      @(negedge clk);
      alu_op = 3'b000; funct = 6'd10; op_a = 32'd100; op_b = 32'd7;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("add_after_rst", 3'b011, 6'd0, 32'd2, 32'd3, 32'd5, 4'b0000, 0, 0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
